riscp_boot_loader: RTL and testbench
====================================

Name: riscp_boot_loader

Overview:
Upstream stage of risc_processor. Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes the words into instruction ROM or data RAM through their write ports. Holds the core in reset (core_start=1) until an END command arrives, then releases it. Replaces hierarchical memory preloading with a synthesizable boot path.

Parameters:
ROM_AW, 5, ROM word-address width (32 instruction words)
RAM_AW, 4, RAM word-address width (16 data words)
CORE_HOLD, 2, cycles core_start stays high after END is accepted (≥1)

Ports:
clk1  in  1  system clock, rising edge
start_n  in  1  asynchronous active-low reset
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_ready  out  1  loader accepts byte this cycle
rom_we  out  1  one-cycle ROM write strobe
rom_addr  out  ROM_AW  ROM word address
rom_wdata  out  32  ROM write data
ram_we  out  1  one-cycle RAM write strobe
ram_addr  out  RAM_AW  RAM word address
ram_wdata  out  32  RAM write data
core_start  out  1  active-high reset/start to risc_processor
boot_done  out  1  high once core released, until reset
err  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous on start_n low. Reset values: state=IDLE, in_ready=0, rom_we=ram_we=0, addresses/wdata=0, core_start=1, boot_done=0, err=0. in_ready rises the first cycle after reset deasserts.
- A byte is transferred only when in_valid && in_ready at a rising clk1 edge. in_data is ignored otherwise.
- Stream format: CMD, then (for CMD 0x01 ROM / 0x02 RAM) ADDR byte, COUNT byte, then 4*COUNT data bytes, MSB first (first byte -> wdata[31:24]). CMD 0xFF = END. Any other CMD -> ERROR.
- ADDR is truncated to the low ROM_AW/RAM_AW bits. COUNT 0 is legal: return to IDLE with no write.
- States:
  - IDLE (in_ready=1): 0x01/0x02 latch target -> ADDR; 0xFF -> RELEASE; other -> ERROR.
  - ADDR (in_ready=1): latch addr -> COUNT.
  - COUNT (in_ready=1): latch remaining=COUNT; 0 -> IDLE, else byte_idx=0 -> DATA.
  - DATA (in_ready=1): shift byte into word; on the 4th byte -> WRITE.
  - WRITE (in_ready=0): exactly one cycle with rom_we or ram_we=1, addr and wdata stable. At the edge: addr+1 (wraps modulo 2^AW), remaining-1. remaining becomes 0 -> IDLE, else -> DATA.
  - RELEASE (in_ready=0): count CORE_HOLD cycles with core_start=1, then -> DONE.
  - DONE (in_ready=0): core_start=0, boot_done=1. Stays until reset.
  - ERROR (in_ready=0): err=1, core_start=1 (core never released). Stays until reset.
- Write latency: a strobe is asserted in the cycle after the 4th byte of a word is accepted. Throughput is one word per 5 cycles at full in_valid.
- The ROM write port and the RAM write port are never strobed in the same cycle.
- Reset mid-load aborts immediately. Partial words are discarded; writes already performed stand.

Optional Feature:
BOOT_CHECKSUM_EN. When defined, each ROM/RAM block with COUNT>0 carries one trailing checksum byte, the XOR of all 4*COUNT data bytes. The checksum is accepted in a CHECK state (in_ready=1) after the last WRITE. On a match the loader goes to IDLE; on a mismatch it goes to ERROR. When not defined, no checksum byte is expected and CHECK does not exist.

Test Plan:
- ROM load: 01 00 01 30 02 00 00 -> one rom_we pulse, rom_addr=0, rom_wdata=0x30020000, in_ready low that cycle only.
- RAM load: 02 00 06, then words 7,2,9,14,45,23 -> six ram_we pulses at addr 0..5 with those values, no rom_we. Then FF -> core_start falls exactly CORE_HOLD+1 cycles after FF is accepted, boot_done=1.
- Wrap/zero count: 02 0F 02 + two words -> writes at RAM addr 15 then 0. Then 01 03 00 -> no strobe, returns to IDLE.
- Bad command: 05 -> err=1, in_ready=0, core_start stays 1. A subsequent FF is ignored.
- Backpressure/reset: in_valid toggled randomly gives words identical to the contiguous case. start_n pulsed low after 2 data bytes -> all outputs return to reset values asynchronously, and the next stream loads correctly.
- With BOOT_CHECKSUM_EN: 01 00 01 30 02 00 06 34 -> write, then IDLE. Checksum 00 instead -> err=1.

Source files
------------

// File: rtl/riscp_boot_loader.sv
// riscp_boot_loader: byte-stream loader filling ROM/RAM, then releasing the core.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte per block.
module riscp_boot_loader #(
  parameter int ROM_AW    = 5,
  parameter int RAM_AW    = 4,
  parameter int CORE_HOLD = 2
) (
  input  logic              clk1,
  input  logic              start_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              core_start,
  output logic              boot_done,
  output logic              err
);

  localparam int AW = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;
  localparam int HW = $clog2(CORE_HOLD + 1);

  localparam logic [7:0] CMD_ROM = 8'h01;
  localparam logic [7:0] CMD_RAM = 8'h02;
  localparam logic [7:0] CMD_END = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_RELEASE,
    S_DONE,
    S_ERROR
`ifdef BOOT_CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          up_q, up_d;
  logic          tgt_ram_q, tgt_ram_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    rem_q, rem_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic [HW-1:0] hold_q, hold_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic accept;
  logic is_mem;
  logic is_end;

  assign accept = in_valid && in_ready;
  assign is_mem = (in_data == CMD_ROM) || (in_data == CMD_RAM);
  assign is_end = (in_data == CMD_END);

  always_ff @(posedge clk1 or negedge start_n) begin
    if (!start_n) begin
      state_q   <= S_IDLE;
      up_q      <= 1'b0;
      tgt_ram_q <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      hold_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      up_q      <= up_d;
      tgt_ram_q <= tgt_ram_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      hold_q    <= hold_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    up_d      = 1'b1;
    tgt_ram_d = tgt_ram_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    word_d    = word_q;
    hold_d    = hold_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      S_IDLE: if (accept) begin
        unique case (1'b1)
          is_mem: begin
            tgt_ram_d = (in_data == CMD_RAM);
            state_d   = S_ADDR;
          end
          is_end: begin
            hold_d  = '0;
            state_d = S_RELEASE;
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_ADDR: if (accept) begin
        addr_d  = in_data[AW-1:0];
        state_d = S_COUNT;
      end
      S_COUNT: if (accept) begin
        rem_d   = in_data;
        idx_d   = '0;
`ifdef BOOT_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = (in_data == 8'd0) ? S_IDLE : S_DATA;
      end
      S_DATA: if (accept) begin
        word_d = {word_q[23:0], in_data};
        idx_d  = idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
        csum_d = csum_q ^ in_data;
`endif
        if (idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_RELEASE: begin
        if (hold_q == HW'(CORE_HOLD)) state_d = S_DONE;
        else hold_d = hold_q + HW'(1);
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: if (accept) begin
        state_d = (in_data == csum_q) ? S_IDLE : S_ERROR;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    rom_we     = 1'b0;
    ram_we     = 1'b0;
    core_start = 1'b1;
    boot_done  = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      S_IDLE, S_ADDR, S_COUNT, S_DATA: in_ready = up_q;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: in_ready = 1'b1;
`endif
      S_WRITE: begin
        rom_we = !tgt_ram_q;
        ram_we = tgt_ram_q;
      end
      S_DONE: begin
        core_start = 1'b0;
        boot_done  = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr  = addr_q[ROM_AW-1:0];
  assign ram_addr  = addr_q[RAM_AW-1:0];
  assign rom_wdata = word_q;
  assign ram_wdata = word_q;

endmodule

// File: tb/tb_riscp_boot_loader.sv
// Bench for riscp_boot_loader: directed + random streams vs a stream-parsing model.
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum path.
module tb_riscp_boot_loader;

  localparam int ROM_AW    = 5;
  localparam int RAM_AW    = 4;
  localparam int CORE_HOLD = 2;

  logic              clk1 = 1'b0;
  logic              start_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              core_start;
  logic              boot_done;
  logic              err;

  riscp_boot_loader #(
    .ROM_AW(ROM_AW),
    .RAM_AW(RAM_AW),
    .CORE_HOLD(CORE_HOLD)
  ) dut (
    .clk1(clk1),
    .start_n(start_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .rom_we(rom_we),
    .rom_addr(rom_addr),
    .rom_wdata(rom_wdata),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .core_start(core_start),
    .boot_done(boot_done),
    .err(err)
  );

  always #5 clk1 = ~clk1;

  int n_assert = 0;
  int n_fail = 0;

  // write log entry: {is_ram, addr, data}
  logic [40:0] wlog[$];
  int both_cnt = 0;
  int rdy_bad = 0;
  int nrdy = 0;

  logic [7:0]  stream[$];
  logic [31:0] words[$];
  logic [40:0] exp_w[$];
  int          exp_st;
  int          exp_len;

  always @(negedge clk1) begin
    if (start_n) begin
      if (rom_we || ram_we) begin
        if (ram_we) wlog.push_back({1'b1, 8'(ram_addr), ram_wdata});
        else        wlog.push_back({1'b0, 8'(rom_addr), rom_wdata});
        if (in_ready) rdy_bad++;
      end
      if (rom_we && ram_we) both_cnt++;
      if (!in_ready) nrdy++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parse the byte stream by its format rules; status 0=idle 1=done 2=error.
  task automatic model();
    int i;
    int n;
    int lim;
    logic [7:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [31:0] w;
    exp_w.delete();
    exp_st = 0;
    i = 0;
    while (i < stream.size()) begin
      cmd = stream[i];
      i++;
      if (cmd == 8'hFF) begin
        exp_st = 1;
        break;
      end
      if (cmd != 8'h01 && cmd != 8'h02) begin
        exp_st = 2;
        break;
      end
      a = stream[i];
      n = int'(stream[i+1]);
      i += 2;
      x = 8'h00;
      lim = (cmd == 8'h02) ? (1 << RAM_AW) : (1 << ROM_AW);
      for (int k = 0; k < n; k++) begin
        w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
        i += 4;
        x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        exp_w.push_back({cmd == 8'h02, 8'((int'(a) + k) % lim), w});
      end
`ifdef BOOT_CHECKSUM_EN
      if (n != 0) begin
        i++;
        if (stream[i-1] != x) begin
          exp_st = 2;
          break;
        end
      end
`endif
    end
    exp_len = i;
  endtask

  task automatic add_block(input logic [7:0] cmd, input logic [7:0] a);
    logic [7:0] x;
    x = 8'h00;
    stream.push_back(cmd);
    stream.push_back(a);
    stream.push_back(8'(words.size()));
    foreach (words[k]) begin
      for (int b = 3; b >= 0; b--) begin
        stream.push_back(words[k][8*b +: 8]);
        x = x ^ words[k][8*b +: 8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    if (words.size() != 0) stream.push_back(x);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp,
                           input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk1);
      in_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? b : 8'($urandom);
      if (in_valid && in_ready) ok = 1'b1;
      @(posedge clk1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    in_valid = 1'b0;
    start_n  = 1'b0;
    @(negedge clk1);
    start_n = 1'b1;
    repeat (2) @(negedge clk1);
  endtask

  task automatic run_stream(input bit bp, input string tag);
    int base;
    bit ok;
    model();
    base = wlog.size();
    for (int i = 0; i < exp_len; i++) begin
      send_byte(stream[i], bp, 64, ok);
      chk({tag, "_accept"}, 64'(ok), 64'd1);
      if (!ok) break;
    end
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk1);
    chk({tag, "_nwrites"}, 64'(wlog.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && base + i < wlog.size(); i++)
      chk({tag, "_write"}, 64'(wlog[base+i]), 64'(exp_w[i]));
    if (exp_st == 2) begin
      chk({tag, "_err"}, 64'(err), 64'd1);
      chk({tag, "_rdy_err"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_err"}, 64'(core_start), 64'd1);
    end else begin
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_rdy_idle"}, 64'(in_ready), 64'd1);
      chk({tag, "_hold"}, 64'(core_start), 64'd1);
    end
  endtask

  task automatic send_end(input string tag);
    bit ok;
    int n;
    send_byte(8'hFF, 1'b0, 16, ok);
    chk({tag, "_end_accept"}, 64'(ok), 64'd1);
    #1 in_valid = 1'b0;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk1);
      #1;
      if (!core_start) begin
        n = c;
        break;
      end
    end
    chk({tag, "_release_lat"}, 64'(n), 64'(CORE_HOLD + 1));
    chk({tag, "_boot_done"}, 64'(boot_done), 64'd1);
    chk({tag, "_rdy_done"}, 64'(in_ready), 64'd0);
    chk({tag, "_err_done"}, 64'(err), 64'd0);
  endtask

  initial begin
    bit ok;
    int base;
    int n0;
    logic [31:0] w0;

    // reset values
    #2 start_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_rom_we", 64'(rom_we), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd1);
    chk("rst_boot_done", 64'(boot_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk1);
    @(negedge clk1);
    start_n = 1'b1;
    #1 chk("rdy_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk1);
    #1 chk("rdy_after_edge", 64'(in_ready), 64'd1);

    // ROM single word
    stream.delete();
    words = '{32'h30020000};
    add_block(8'h01, 8'h00);
    n0 = nrdy;
    run_stream(1'b0, "rom1");
    chk("rom1_rdy_low_cycles", 64'(nrdy - n0), 64'd1);

    // RAM six words, then END
    stream.delete();
    words = '{32'd7, 32'd2, 32'd9, 32'd14, 32'd45, 32'd23};
    add_block(8'h02, 8'h00);
    run_stream(1'b0, "ram6");
    send_end("ram6");

    // address wrap and zero count
    do_reset();
    stream.delete();
    words = '{$urandom, $urandom};
    add_block(8'h02, 8'h0F);
    words.delete();
    add_block(8'h01, 8'h03);
    run_stream(1'b0, "wrap");
    send_end("wrap");

    // bad command, END afterwards ignored
    do_reset();
    stream = '{8'h05};
    run_stream(1'b0, "badcmd");
    send_byte(8'hFF, 1'b0, 8, ok);
    chk("badcmd_end_ignored", 64'(ok), 64'd0);
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (CORE_HOLD + 3) @(negedge clk1);
    chk("badcmd_err_sticky", 64'(err), 64'd1);
    chk("badcmd_core_held", 64'(core_start), 64'd1);
    chk("badcmd_not_done", 64'(boot_done), 64'd0);

    // random stream with and without backpressure
    do_reset();
    stream.delete();
    words.delete();
    repeat ($urandom_range(1, 3)) words.push_back($urandom);
    add_block(8'h01, 8'($urandom));
    words.delete();
    repeat ($urandom_range(0, 3)) words.push_back($urandom);
    add_block(8'h02, 8'($urandom));
    words.delete();
    repeat ($urandom_range(2, 4)) words.push_back($urandom);
    add_block(8'h02, 8'($urandom));
    run_stream(1'b1, "bp");
    do_reset();
    run_stream(1'b0, "nobp");

    // reset mid-load after two bytes of the second word
    do_reset();
    w0 = $urandom;
    stream.delete();
    words = '{w0, $urandom};
    add_block(8'h01, 8'h02);
    base = wlog.size();
    for (int i = 0; i < 9; i++) begin
      send_byte(stream[i], 1'b0, 32, ok);
      chk("midrst_accept", 64'(ok), 64'd1);
    end
    #2 start_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_rom_we", 64'(rom_we), 64'd0);
    chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
    chk("midrst_rom_wdata", 64'(rom_wdata), 64'd0);
    chk("midrst_core_start", 64'(core_start), 64'd1);
    chk("midrst_nwrites", 64'(wlog.size() - base), 64'd1);
    if (wlog.size() > base)
      chk("midrst_write", 64'(wlog[base]), 64'({1'b0, 8'd2, w0}));
    in_valid = 1'b0;
    @(negedge clk1);
    start_n = 1'b1;
    repeat (2) @(negedge clk1);
    stream.delete();
    words = '{$urandom, $urandom, $urandom};
    add_block(8'h01, 8'h1E);
    run_stream(1'b0, "after_rst");
    send_end("after_rst");

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    stream = '{8'h01, 8'h00, 8'h01, 8'h30, 8'h02, 8'h00, 8'h06, 8'h34};
    run_stream(1'b0, "csum_ok");
    stream = '{8'h01, 8'h00, 8'h01, 8'h30, 8'h02, 8'h00, 8'h06, 8'h00};
    run_stream(1'b0, "csum_bad");
    chk("csum_bad_status", 64'(exp_st), 64'd2);
`endif

    chk("never_both_we", 64'(both_cnt), 64'd0);
    chk("rdy_low_on_write", 64'(rdy_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
